uart_dbg_bridge: RTL and testbench

//  UART-to-iob debug bridge: the bus initiator that drives the memory-mapped

---
 rtl/uart_dbg_bridge_pkg.sv | 32 +++
 rtl/uart_dbg_bridge_rx.sv | 97 +++++++++
 rtl/uart_dbg_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_dbg_bridge.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_bridge_pkg.sv
// Shared constants for the UART debug bridge: opcodes, response codes and
// state encodings (kept in step with the host-side scripts).
package uart_dbg_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // Frame FSM
    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Byte receiver FSM
    typedef enum logic [1:0] {
        R_HUNT  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_e;

    // Terminal value of a 16-bit cycle counter that wraps every div cycles
    function automatic logic [15:0] cnt_last(input int div);
        return 16'(div - 1);
    endfunction

endpackage

// File: rtl/uart_dbg_bridge_rx.sv
// 8N1 byte receiver: synchroniser, start-bit validation, mid-bit sampling
// and stop-bit check. Emits a 1-cycle strobe per good byte or framing error.
module uart_byte_rx
    import uart_dbg_bridge_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frm_err
);

    localparam logic [15:0] BIT_LAST  = cnt_last(BAUD_DIV);
    localparam logic [15:0] HALF_LAST = cnt_last(BAUD_DIV / 2);

    // sync_q[0], sync_q[1] are the synchroniser; sync_q[2] is the previous
    // synchronised value used for falling-edge detection.
    logic [2:0]  sync_q, sync_d;
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;

    // Next-state logic: hunt for an edge, confirm the start bit at half a
    // bit, then sample each bit at its centre.
    always_comb begin
        sync_d  = {sync_q[1:0], rx_pin};
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            R_HUNT: begin
                cnt_d = 16'd0;
                if (sync_q[2] && !sync_q[1]) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    bit_d = 3'd0;
                    // Line back high at mid-start: treat as a glitch
                    state_d = sync_q[1] ? R_HUNT : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    sh_d  = {sync_q[1], sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = R_HUNT;
                    vld_d   = sync_q[1];
                    err_d   = !sync_q[1];
                end
            end
            default: state_d = R_HUNT;
        endcase
    end

    // State registers; sync flops reset high so reset never fakes a start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 3'b111;
            state_q <= R_HUNT;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign byte_vld  = vld_q;
    assign byte_data = sh_q;
    assign frm_err   = err_q;

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-to-iob debug bridge: decodes host command frames, runs one iob
// transaction per frame and serialises the response back to the host.
module uart_dbg_bridge
    import uart_dbg_bridge_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int BUS_TO   = 1024,
    parameter int FRAME_TO = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        iob_val,
    input  logic        iob_rdy,
    output logic [31:0] iob_adr,
    output logic [3:0]  iob_wen,
    output logic [31:0] iob_wdat,
    input  logic [31:0] iob_rdat,
    output logic        busy
);

    localparam logic [15:0] BIT_LAST   = cnt_last(BAUD_DIV);
    localparam logic [15:0] BUS_LAST   = cnt_last(BUS_TO);
    localparam logic [15:0] FRAME_LAST = cnt_last(FRAME_TO);

    logic       rx_vld, rx_err;
    logic [7:0] rx_byte;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (rx_pin),
        .byte_vld  (rx_vld),
        .byte_data (rx_byte),
        .frm_err   (rx_err)
    );

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  wen_q, wen_d;
    logic        val_q, val_d;
    logic        low_seen_q, low_seen_d;
    logic [15:0] bus_cnt_q, bus_cnt_d;
    logic [15:0] gap_cyc_q, gap_cyc_d;
    logic [15:0] gap_bit_q, gap_bit_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  rsp_left_q, rsp_left_d;
    logic        busy_q, busy_d;
    logic        tx_pin_q, tx_pin_d;
    logic        tx_busy_q, tx_busy_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic        tx_load, tx_done, tx_free, gap_expired;

    // Frame FSM, iob handshake and TX shifter next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        is_wr_d    = is_wr_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        wen_d      = wen_q;
        val_d      = val_q;
        low_seen_d = low_seen_q | ~iob_rdy;
        bus_cnt_d  = bus_cnt_q;
        rsp_d      = rsp_q;
        rsp_left_d = rsp_left_q;
        tx_pin_d   = tx_pin_q;
        tx_busy_d  = tx_busy_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        tx_load    = 1'b0;
        tx_done    = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);
        tx_free    = !tx_busy_q || tx_done;

        // Inter-byte gap timer, counted in whole bit-times
        gap_expired = (gap_cyc_q == BIT_LAST) && (gap_bit_q == FRAME_LAST);
        gap_cyc_d   = 16'd0;
        gap_bit_d   = 16'd0;
        if ((state_q == S_ADDR || state_q == S_DATA) && !rx_vld) begin
            gap_cyc_d = gap_cyc_q + 16'd1;
            gap_bit_d = gap_bit_q;
            if (gap_cyc_q == BIT_LAST) begin
                gap_cyc_d = 16'd0;
                gap_bit_d = gap_bit_q + 16'd1;
            end
        end

        case (state_q)
            S_OP: begin
                if (rx_vld) begin
                    idx_d = 2'd0;
                    if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                        is_wr_d = (rx_byte == OP_WR);
                        state_d = S_ADDR;
                    end else begin
                        rsp_d      = {24'h0, RSP_ERR};
                        rsp_left_d = 3'd1;
                        state_d    = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_vld) begin
                    adr_d = {rx_byte, adr_q[31:8]};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            wen_d     = 4'h0;
                            bus_cnt_d = 16'd0;
                            state_d   = S_BUS;
                        end
                    end
                end else if (rx_err || gap_expired) begin
                    state_d = S_OP;
                end
            end
            S_DATA: begin
                if (rx_vld) begin
                    wdat_d = {rx_byte, wdat_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wen_d     = 4'hF;
                        bus_cnt_d = 16'd0;
                        state_d   = S_BUS;
                    end
                end else if (rx_err || gap_expired) begin
                    state_d = S_OP;
                end
            end
            S_BUS: begin
                if (val_q) begin
                    bus_cnt_d = bus_cnt_q + 16'd1;
                    if (iob_rdy) begin
                        val_d      = 1'b0;
                        wen_d      = 4'h0;
                        low_seen_d = 1'b0;
                        rsp_d      = is_wr_q ? {24'h0, RSP_OK} : iob_rdat;
                        rsp_left_d = is_wr_q ? 3'd1 : 3'd4;
                        state_d    = S_RESP;
                    end else if (bus_cnt_q == BUS_LAST) begin
                        val_d      = 1'b0;
                        wen_d      = 4'h0;
                        rsp_d      = {24'h0, RSP_ERR};
                        rsp_left_d = 3'd1;
                        state_d    = S_RESP;
                    end
                end else if (low_seen_q || !iob_rdy) begin
                    // Only start once rdy has been low since the last cycle
                    val_d = 1'b1;
                end
            end
            S_RESP: begin
                if (tx_free) begin
                    if (rsp_left_q != 3'd0) begin
                        tx_load    = 1'b1;
                        rsp_d      = {8'h00, rsp_q[31:8]};
                        rsp_left_d = rsp_left_q - 3'd1;
                    end else begin
                        state_d = S_OP;
                    end
                end
            end
            default: state_d = S_OP;
        endcase

        // TX shifter: start bit goes out the cycle after load
        if (tx_load) begin
            tx_pin_d  = 1'b0;
            tx_sh_d   = {1'b1, rsp_q[7:0]};
            tx_bit_d  = 4'd0;
            tx_cnt_d  = 16'd0;
            tx_busy_d = 1'b1;
        end else if (tx_busy_q) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = 16'd0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_pin_d  = 1'b1;
                end else begin
                    tx_pin_d = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
        end

        busy_d = (state_d != S_OP);
    end

    // All bridge state; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_OP;
            idx_q      <= 2'd0;
            is_wr_q    <= 1'b0;
            adr_q      <= 32'd0;
            wdat_q     <= 32'd0;
            wen_q      <= 4'h0;
            val_q      <= 1'b0;
            low_seen_q <= 1'b0;
            bus_cnt_q  <= 16'd0;
            gap_cyc_q  <= 16'd0;
            gap_bit_q  <= 16'd0;
            rsp_q      <= 32'd0;
            rsp_left_q <= 3'd0;
            busy_q     <= 1'b0;
            tx_pin_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_sh_q    <= 9'h1FF;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_wr_q    <= is_wr_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            wen_q      <= wen_d;
            val_q      <= val_d;
            low_seen_q <= low_seen_d;
            bus_cnt_q  <= bus_cnt_d;
            gap_cyc_q  <= gap_cyc_d;
            gap_bit_q  <= gap_bit_d;
            rsp_q      <= rsp_d;
            rsp_left_q <= rsp_left_d;
            busy_q     <= busy_d;
            tx_pin_q   <= tx_pin_d;
            tx_busy_q  <= tx_busy_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    assign tx_pin   = tx_pin_q;
    assign iob_val  = val_q;
    assign iob_adr  = adr_q;
    assign iob_wen  = wen_q;
    assign iob_wdat = wdat_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge with a bus-slave model, a serial
// response monitor and expected-value queues.
module tb_uart_dbg_bridge;

    localparam int B      = 8;
    localparam int BUS_TO = 40;
    localparam int FR_TO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic        iob_val;
    logic        iob_rdy = 1'b0;
    logic [31:0] iob_adr;
    logic [3:0]  iob_wen;
    logic [31:0] iob_wdat;
    logic [31:0] iob_rdat = 32'h0;
    logic        busy;

    uart_dbg_bridge #(.BAUD_DIV(B), .BUS_TO(BUS_TO), .FRAME_TO(FR_TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_pin   (rx_pin),
        .tx_pin   (tx_pin),
        .iob_val  (iob_val),
        .iob_rdy  (iob_rdy),
        .iob_adr  (iob_adr),
        .iob_wen  (iob_wen),
        .iob_wdat (iob_wdat),
        .iob_rdat (iob_rdat),
        .busy     (busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int bus_seen = 0;
    int gap_n = 0;
    int unsigned last_start = 0;
    int unsigned prev_start = 0;
    int unsigned done_cyc = 0;
    bit slave_en = 1'b1;
    bit ign_tx = 1'b0;
    bit chk_gap = 1'b0;

    logic [7:0]  exp_tx_q[$];
    logic [67:0] exp_bus_q[$];   // {adr, wen, wdat}
    logic [31:0] rdat_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    // Bus slave: registered rdy one cycle after val, checks each request
    initial begin
        logic [67:0] e;
        forever begin
            @(negedge clk);
            if (iob_rdy) begin
                iob_rdy = 1'b0;
            end else if (slave_en && iob_val === 1'b1) begin
                bus_seen++;
                chk("bus_pending", 32'(exp_bus_q.size() != 0), 32'd1);
                if (exp_bus_q.size() != 0) begin
                    e = exp_bus_q.pop_front();
                    chk("bus_adr", iob_adr, e[67:36]);
                    chk("bus_wen", 32'(iob_wen), 32'(e[35:32]));
                    if (e[35:32] == 4'hF) chk("bus_wdat", iob_wdat, e[31:0]);
                    if (e[35:32] == 4'h0 && rdat_q.size() != 0) iob_rdat = rdat_q.pop_front();
                end
                iob_rdy = 1'b1;
            end
        end
    end

    // Serial monitor: decode each tx byte at bit centres
    initial begin
        logic [7:0] d;
        logic       stp;
        forever begin
            @(negedge clk);
            if (tx_pin === 1'b0) begin
                prev_start = last_start;
                last_start = cyc;
                if (chk_gap && !ign_tx) begin
                    if (gap_n > 0) chk("tx_gap", last_start - prev_start, 32'(10 * B));
                    gap_n++;
                end
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    d[i] = tx_pin;
                end
                repeat (B) @(negedge clk);
                stp = tx_pin;
                if (!ign_tx) begin
                    tx_seen++;
                    chk("tx_stop", 32'(stp), 32'd1);
                    chk("tx_pending", 32'(exp_tx_q.size() != 0), 32'd1);
                    if (exp_tx_q.size() != 0) chk("tx_byte", 32'(d), 32'(exp_tx_q.pop_front()));
                end
            end
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_pin = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (B) @(negedge clk);
        end
        rx_pin = stop;
        repeat (B) @(negedge clk);
        rx_pin = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic send_write(input logic [31:0] adr, input logic [31:0] dat);
        exp_bus_q.push_back({adr, 4'hF, dat});
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        send_word(adr);
        send_word(dat);
    endtask

    task automatic send_read(input logic [31:0] adr, input logic [31:0] rdat);
        exp_bus_q.push_back({adr, 4'h0, 32'h0});
        rdat_q.push_back(rdat);
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(rdat[8*i +: 8]);
        send_byte(8'h52, 1'b1);
        send_word(adr);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_bus_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        chk(tag, 32'(n < 3000), 32'd1);
    endtask

    // Directed sequence
    initial begin
        int n;
        int hi;
        int t0;
        int b0;

        repeat (3) @(negedge clk);
        chk("rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("rst_val", 32'(iob_val), 32'd0);
        chk("rst_adr", iob_adr, 32'd0);
        chk("rst_wdat", iob_wdat, 32'd0);
        chk("rst_wen", 32'(iob_wen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: write
        exp_bus_q.push_back({32'h1000000C, 4'hF, 32'h00000041});
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        repeat (2) @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        send_word(32'h1000000C);
        send_word(32'h00000041);
        wait_done("t1_done");
        chk("t1_wen_idle", 32'(iob_wen), 32'd0);

        // 2: read with back-to-back response bytes
        chk_gap = 1'b1;
        gap_n = 0;
        send_read(32'h10000004, 32'h12345678);
        wait_done("t2_done");
        chk("t2_nbytes", 32'(gap_n), 32'd4);
        chk_gap = 1'b0;

        // 3: bad opcode, then a normal read
        b0 = bus_seen;
        exp_tx_q.push_back(8'h45);
        send_byte(8'h33, 1'b1);
        wait_done("t3_err_done");
        chk("t3_no_bus", 32'(bus_seen), 32'(b0));
        send_read(32'h10000008, 32'hA5C30F96);
        wait_done("t3_rd_done");

        // 4: bus timeout
        slave_en = 1'b0;
        exp_tx_q.push_back(8'h45);
        send_byte(8'h52, 1'b1);
        send_word(32'h10000030);
        n = 0;
        while (iob_val !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t4_val_seen", 32'(n < 500), 32'd1);
        hi = 0;
        while (iob_val === 1'b1 && hi < 500) begin
            hi++;
            @(negedge clk);
        end
        chk("t4_val_cycles", 32'(hi), 32'(BUS_TO));
        wait_done("t4_done");
        chk("t4_busy_fall", done_cyc - last_start, 32'(10 * B));
        slave_en = 1'b1;

        // 5: stalled frame discarded, then a read
        t0 = tx_seen;
        b0 = bus_seen;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20 * B) @(negedge clk);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_no_tx", 32'(tx_seen), 32'(t0));
        chk("t5_no_bus", 32'(bus_seen), 32'(b0));
        send_read(32'h10000010, 32'hDEADBEEF);
        wait_done("t5_done");

        // 6: framing error and glitch, both silent
        t0 = tx_seen;
        b0 = bus_seen;
        send_byte(8'h52, 1'b1);
        send_byte(8'h04, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_frm_busy", 32'(busy), 32'd0);
        rx_pin = 1'b0;
        repeat ((3 * B) / 10) @(negedge clk);
        rx_pin = 1'b1;
        repeat (12 * B) @(negedge clk);
        chk("t6_glitch_busy", 32'(busy), 32'd0);
        chk("t6_no_tx", 32'(tx_seen), 32'(t0));
        chk("t6_no_bus", 32'(bus_seen), 32'(b0));
        send_read(32'h10000014, 32'h0BADF00D);
        wait_done("t6_rd_done");

        // 6: reset during a bus cycle
        slave_en = 1'b0;
        send_byte(8'h52, 1'b1);
        send_word(32'h10000018);
        n = 0;
        while (iob_val !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_bus_val_seen", 32'(n < 500), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_bus_rst_val", 32'(iob_val), 32'd0);
        chk("t6_bus_rst_tx", 32'(tx_pin), 32'd1);
        chk("t6_bus_rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        slave_en = 1'b1;
        repeat (2 * B) @(negedge clk);

        // 6: reset during the response
        ign_tx = 1'b1;
        exp_bus_q.push_back({32'h1000001C, 4'h0, 32'h0});
        rdat_q.push_back(32'h00000000);
        send_byte(8'h52, 1'b1);
        send_word(32'h1000001C);
        n = 0;
        while (tx_pin !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_resp_seen", 32'(n < 500), 32'd1);
        repeat (3 * B) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_resp_rst_tx", 32'(tx_pin), 32'd1);
        chk("t6_resp_rst_val", 32'(iob_val), 32'd0);
        chk("t6_resp_rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (12 * B) @(negedge clk);
        ign_tx = 1'b0;

        // Recovery after reset
        send_write(32'h10000020, 32'hCAFEF00D);
        wait_done("t6_wr_done");
        chk("end_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
        chk("end_bus_q_empty", 32'(exp_bus_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
